// File: rtl/approx_add_pipe.sv
// Pipelined approximate adder: OR-approximated low bits, exact ripple above; STAGES-cycle latency.
// Global stall when out_valid & !out_ready (in_ready drops); APPROX_ADD_ERRCNT_EN adds err_cnt.
module approx_add_pipe #(
  parameter int WIDTH       = 16,
  parameter int STAGES      = 2,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             exact_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef APPROX_ADD_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam int SEG = WIDTH / STAGES;

  // Rank k holds operands/mode with segments 0..k-1 already summed; rank STAGES is the output.
  logic [WIDTH-1:0] ra [STAGES];
  logic [WIDTH-1:0] rb [STAGES];
  logic             rm [STAGES];
  logic [WIDTH-1:0] rs [STAGES+1];
  logic [STAGES:0]  rc;
  logic [STAGES:0]  rv;

  logic [WIDTH-1:0] ns [STAGES];
  logic [STAGES-1:0] nc;
  logic              cy;
  logic              stall;
  logic              accept;

  assign out_valid = rv[STAGES] & ~rst;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready & ~rst;
  assign sum       = rst ? '0 : {rc[STAGES], rs[STAGES]};

  always_comb begin
    cy = 1'b0;
    nc = '0;
    for (int k = 0; k < STAGES; k++) begin
      ns[k] = rs[k];
      cy    = rc[k];
      for (int j = 0; j < SEG; j++) begin
        if (!rm[k] && (k*SEG + j) < APPROX_BITS) begin
          // Approximate region: OR sum, only its top bit pair generates a carry.
          ns[k][k*SEG + j] = ra[k][k*SEG + j] | rb[k][k*SEG + j];
          cy = ((k*SEG + j) == APPROX_BITS - 1) ? (ra[k][k*SEG + j] & rb[k][k*SEG + j]) : 1'b0;
        end else begin
          ns[k][k*SEG + j] = ra[k][k*SEG + j] ^ rb[k][k*SEG + j] ^ cy;
          cy = (ra[k][k*SEG + j] & rb[k][k*SEG + j]) | (cy & (ra[k][k*SEG + j] ^ rb[k][k*SEG + j]));
        end
      end
      nc[k] = cy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rv <= '0;
      rc <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
        rm[k] <= 1'b0;
      end
      for (int k = 0; k <= STAGES; k++) rs[k] <= '0;
    end else if (!stall) begin
      rv    <= {rv[STAGES-1:0], accept};
      rc    <= {nc, 1'b0};
      ra[0] <= accept ? A : '0;
      rb[0] <= accept ? B : '0;
      rm[0] <= accept & exact_mode;
      rs[0] <= '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        ra[k+1] <= ra[k];
        rb[k+1] <= rb[k];
        rm[k+1] <= rm[k];
      end
      for (int k = 0; k < STAGES; k++) rs[k+1] <= ns[k];
    end
  end

`ifdef APPROX_ADD_ERRCNT_EN
  // Upper bits are exact given their carry-in, so a mismatch is decided by the low bits alone.
  logic [WIDTH-1:0] lo_mask;
  logic [WIDTH:0]   lo_sum;
  logic             lo_cy;
  logic             lo_mis;
  logic [STAGES:0]  re;

  always_comb begin
    lo_mask = '0;
    lo_cy   = 1'b0;
    for (int i = 0; i < APPROX_BITS; i++) begin
      lo_mask[i] = 1'b1;
      lo_cy      = A[i] & B[i];
    end
    lo_sum = {1'b0, A & lo_mask} + {1'b0, B & lo_mask};
    lo_mis = (((A | B) & lo_mask) != (lo_sum[WIDTH-1:0] & lo_mask)) ||
             (lo_cy != lo_sum[APPROX_BITS]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      re      <= '0;
      err_cnt <= '0;
    end else begin
      if (!stall) re <= {re[STAGES-1:0], accept & ~exact_mode & lo_mis};
      if (out_valid && out_ready && re[STAGES] && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe (WIDTH=16, STAGES=2, APPROX_BITS=4): vector table, random traffic, stall/reset sequences.
module tb_approx_add_pipe;

  localparam int W = 16;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, exact_mode, out_valid, out_ready;
  logic [W-1:0]  A, B;
  logic [W:0]    sum;
  logic [W:0]    drv_exp;
`ifdef APPROX_ADD_ERRCNT_EN
  logic [15:0]   err_cnt;
`endif

  approx_add_pipe #(.WIDTH(W), .STAGES(S), .APPROX_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .exact_mode(exact_mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
`ifdef APPROX_ADD_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic m; logic [W:0] exp; } vec_t;
  typedef struct { logic [W:0] exp; int acc; int st; } sb_t;

  vec_t tbl [13];
  sb_t  q [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Reference: low nibble ORed, carry from bit 3 pair, upper 12 bits added exactly.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    logic [12:0] hi;
    if (m) return {1'b0, a} + {1'b0, b};
    hi = {1'b0, a[15:4]} + {1'b0, b[15:4]} + {12'd0, a[3] & b[3]};
    return {hi, a[3:0] | b[3:0]};
  endfunction

  // Scoreboard: push on handshake, pop/compare on retire; latency grows by one per stall cycle.
  always @(negedge clk) begin
    sb_t e;
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got sum 0x%0h with nothing outstanding (t=%0t)", sum, $time);
        end else begin
          e = q.pop_front();
          chk("sum", 32'(sum), 32'(e.exp));
          chk("latency", cyc - e.acc, S + stalls - e.st);
        end
      end
      if (out_valid && !out_ready) stalls++;
      if (in_valid && in_ready) q.push_back('{drv_exp, cyc + 1, stalls});
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                      input logic [W:0] e, input bit release_bp);
    A = a; B = b; exact_mode = m; drv_exp = e; in_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t == 40) begin fail_now("send"); break; end
      @(posedge clk); #1;
      if (release_bp) out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; ; t++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !out_valid) break;
      if (t == 100) begin fail_now("drain"); break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    logic rm;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; exact_mode = 1'b0; out_ready = 1'b1; drv_exp = '0;

    tbl[0]  = '{16'h000F, 16'h0001, 1'b0, 17'h0000F};
    tbl[1]  = '{16'h000F, 16'h0001, 1'b1, 17'h00010};
    tbl[2]  = '{16'hFFFF, 16'h0001, 1'b0, 17'h0FFFF};
    tbl[3]  = '{16'hFFFF, 16'h0001, 1'b1, 17'h10000};
    tbl[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE};
    tbl[5]  = '{16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFF};
    tbl[6]  = '{16'h0010, 16'h0010, 1'b0, 17'h00020};
    tbl[7]  = '{16'h0008, 16'h0008, 1'b0, 17'h00018};
    tbl[8]  = '{16'h0080, 16'h0080, 1'b0, 17'h00100};
    tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    tbl[10] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
    tbl[11] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
    tbl[12] = '{16'h000C, 16'h0004, 1'b0, 17'h0000C};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    chk("post_rst_sum", 32'(sum), 0);
    chk("post_rst_in_ready", 32'(in_ready), 1);
`ifdef APPROX_ADD_ERRCNT_EN
    chk("rst_err_cnt", 32'(err_cnt), 0);
`endif
    @(posedge clk); #1;

    // Back-to-back table vectors at full throughput.
    for (int i = 0; i < 13; i++) send(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].exp, 1'b0);
    drain();

    // Random traffic with random backpressure and occasional idle cycles.
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      send(ra, rb, rm, model(ra, rb, rm), 1'b1);
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    drain();

    // Stall: three results queued behind a held output for three cycles.
    out_ready = 1'b0;
    send(16'h0001, 16'h0001, 1'b1, 17'h00002, 1'b0);
    send(16'h0002, 16'h0002, 1'b1, 17'h00004, 1'b0);
    send(16'h0003, 16'h0003, 1'b1, 17'h00006, 1'b0);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_sum", 32'(sum), 32'h00002);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset pulse with two transactions in flight.
    send(16'h0011, 16'h0022, 1'b1, model(16'h0011, 16'h0022, 1'b1), 1'b0);
    send(16'h00F0, 16'h000F, 1'b0, model(16'h00F0, 16'h000F, 1'b0), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_sum", 32'(sum), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int t = 0; t < 6; t++) begin @(negedge clk); seen += int'(out_valid); end
    chk("midrst_flush", seen, 0);
    @(posedge clk); #1;

    // Reset while the output is stalled.
    out_ready = 1'b0;
    send(16'h0005, 16'h0005, 1'b1, 17'h0000A, 1'b0);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 5; t++) begin @(negedge clk); seen += int'(out_valid); end
    chk("stallrst_flush", seen, 0);
    chk("stallrst_sum", 32'(sum), 0);
    @(posedge clk); #1;

`ifdef APPROX_ADD_ERRCNT_EN
    chk("errcnt_cleared", 32'(err_cnt), 0);
    send(16'h000F, 16'h0001, 1'b0, 17'h0000F, 1'b0);
    send(16'h0010, 16'h0010, 1'b0, 17'h00020, 1'b0);
    send(16'h000F, 16'h0001, 1'b1, 17'h00010, 1'b0);
    drain();
    chk("errcnt", 32'(err_cnt), 1);
`endif

    // Post-reset sanity: pipeline still works.
    send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/approx_add_pipe.md
APPROX_ADD_PIPE -- requirements
Module: approx_add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter STAGES, default 2: number of pipeline segments; WIDTH divisible by STAGES; segment width SEG = WIDTH/STAGES.
REQ-003 SHALL have parameter APPROX_BITS, default 4: number of approximate LSBs; 0 <= APPROX_BITS <= SEG.
REQ-004 SHALL have ports: clk in 1, rising-edge clock. One clock only; reset is synchronous and active-high.
REQ-005 SHALL have ports: rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: in_valid in 1, operands present; in_ready out 1, operands accepted when both high.
REQ-007 SHALL have ports: A in WIDTH, B in WIDTH, exact_mode in 1 (1 = disable approximation for this transaction).
REQ-008 SHALL have ports: out_valid out 1, out_ready in 1, sum out WIDTH+1 (MSB = carry out).

Function
REQ-009 SHALL compute sum as follows when exact_mode=0: bits [APPROX_BITS-1:0] = A|B bitwise.
REQ-010 SHALL generate the carry into bit APPROX_BITS from A[APPROX_BITS-1]&B[APPROX_BITS-1]; this carry is 0 when APPROX_BITS=0.
REQ-011 SHALL compute upper bits exactly, as a ripple carry from bit APPROX_BITS to the carry-out.
REQ-012 SHALL produce sum = A+B exactly, zero-extended to WIDTH+1, when exact_mode=1.
REQ-013 SHALL capture exact_mode together with A and B on acceptance, so mode is per transaction.
REQ-014 SHALL compute, in segment k (0..STAGES-1), bits [k*SEG +: SEG] from the registered carry of segment k-1.
REQ-015 SHALL skew-delay operand bits not yet consumed through registers alongside the pipeline.
REQ-016 SHALL assert out_valid exactly STAGES cycles after acceptance when no stall occurs.
REQ-017 SHALL sustain a throughput of one transaction per cycle.
REQ-018 SHALL apply a global stall: stall = out_valid & !out_ready. All stage registers and valid bits hold, and in_ready = !stall.
REQ-019 SHALL shift the pipeline when not stalled. Empty stages (bubbles) also shift and are not compressed.
REQ-020 SHALL hold sum and out_valid stable while stalled.
REQ-021 SHALL deliver results in acceptance order with no loss or duplication.
REQ-022 SHALL accept a new transaction and retire the last-stage transaction in the same cycle (in_valid, in_ready, out_valid and out_ready all high).
REQ-023 SHALL give the maximum operands 0xFFFF+0xFFFF (WIDTH=16, exact) sum = 0x1FFFE; carry-out occupies sum[WIDTH].

Reset
REQ-024 SHALL clear all stage valid bits on rst=1 at a clock edge. Any in-flight transactions are discarded, including a reset asserted mid-stall.
REQ-025 SHALL hold out_valid=0, sum=0 and in_ready=1 during and after reset.
REQ-026 SHALL ignore in_valid while rst=1, and accept no transaction in that cycle.

Configuration
REQ-027 SHALL, when APPROX_ADD_ERRCNT_EN is defined, add output err_cnt (16 bits). err_cnt increments by 1 on each retired transaction whose approximate result differs from exact A+B.
REQ-028 SHALL, in that configuration, retire a transaction only on out_valid & out_ready, and count only transactions with exact_mode=0.
REQ-029 SHALL, in that configuration, saturate err_cnt at 0xFFFF and reset it to 0 with rst.
REQ-030 SHALL, when APPROX_ADD_ERRCNT_EN is undefined, have no err_cnt port and no exact-reference logic; functional behaviour is otherwise identical.

Verification (WIDTH=16, STAGES=2, APPROX_BITS=4)
REQ-031 SHALL cover approximate mode: A=0x000F, B=0x0001, exact_mode=0 -> sum=0x0000F two cycles after acceptance.
REQ-032 SHALL cover exact mode: A=0x000F, B=0x0001, exact_mode=1 -> sum=0x00010.
REQ-033 SHALL cover carry across segments: A=0xFFFF, B=0x0001, exact_mode=0 -> 0x0FFFF; exact_mode=1 -> 0x10000.
REQ-034 SHALL cover stall: three back-to-back inputs 1+1, 2+2, 3+3 with out_ready low for 3 cycles once the first result is valid.
- Required: sum=0x00002 held stable and in_ready=0 throughout the stall.
- Required: then 0x00002, 0x00004, 0x00006 in order with no loss or duplication.
REQ-035 SHALL cover reset mid-flight: two transactions accepted, rst pulsed one cycle -> out_valid stays 0 and neither result ever appears.
REQ-036 SHALL cover the error counter (APPROX_ADD_ERRCNT_EN defined): 0x000F+0x0001 (mismatch), 0x0010+0x0010 (match), 0x000F+0x0001 with exact_mode=1 -> err_cnt=1.
